// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, one-word-per-line data cache for the core's MEM stage.
// Loads hit in zero cycles. Stores are write-through and do not allocate.
// Byte stores that miss do a read-modify-write against main memory.
//
// Byte ordering: byte 0 is the lowest address and sits in the most
// significant lane of a word (word 0xAABBCCDD -> byte0=AA ... byte3=DD).
//
// Optional feature: define DCACHE_STATS_EN to add hit_count / miss_count.
//
// Parameters
//   LINES        number of lines (power of two, 2..64)
//   MEM_LATENCY  main-memory cycles per read or write (1..15)
//
// Ports
//   clk             sole clock, rising edge
//   rst_b           asynchronous reset, ACTIVE-HIGH despite the name
//   cache_en        request valid from the core
//   mem_write       1 = store, 0 = load
//   is_LB_SB        1 = byte access, 0 = word access
//   addr            byte address
//   wdata           store data; byte stores use wdata[7:0]
//   hit             request completes this cycle
//   cache_data_out  addressed word on a load completion
//   mem_block       addr[1:0] of the completing request
//   mem_addr        word-aligned main-memory address
//   mem_data_in     write data to main memory
//   mem_write_en    main-memory write strobe
//   mem_data_out    read data from main memory
//   hit_count       completed load hits   (DCACHE_STATS_EN only)
//   miss_count      completed load misses (DCACHE_STATS_EN only)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | lookup; load hits complete here, misses/stores leave
// READ_WAIT  | waiting on a memory read (load refill or byte-store RMW read)
// WRITE_WAIT | holding a memory write for MEM_LATENCY cycles
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int LINES       = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            cache_en,
    input  logic            mem_write,
    input  logic            is_LB_SB,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic            hit,
    output logic [0:3][7:0] cache_data_out,
    output logic [1:0]      mem_block,
    output logic [31:0]     mem_addr,
    output logic [0:3][7:0] mem_data_in,
    output logic            mem_write_en,
    input  logic [0:3][7:0] mem_data_out
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [TW-1:0]    r_tag  [LINES];
    logic [0:3][7:0]  r_data [LINES];
    logic [LINES-1:0] r_valid;

    // Request captured when leaving IDLE so the transaction is independent
    // of what the core does with its inputs afterwards.
    logic [31:0]      r_addr;
    logic [7:0]       r_wbyte;
    logic             r_is_store;
    logic             r_store_hit;
    logic [3:0]       r_cnt;
    logic [31:0]      r_mem_addr;
    logic [0:3][7:0]  r_mem_data_in;

    logic [IW-1:0]    w_idx;
    logic [TW-1:0]    w_tag;
    logic [IW-1:0]    w_r_idx;
    logic [TW-1:0]    w_r_tag;
    logic             w_lookup_hit;
    logic             w_cnt_zero;
    logic             w_fill;
    logic             w_store_done;
    logic             w_load_hit_idle;

    function automatic logic [0:3][7:0] merge_byte(
        input logic [0:3][7:0] word,
        input logic [1:0]      lane,
        input logic [7:0]      b
    );
        logic [0:3][7:0] res;
        res       = word;
        res[lane] = b;
        return res;
    endfunction

    assign w_idx        = addr[IW+1:2];
    assign w_tag        = addr[31:IW+2];
    assign w_r_idx      = r_addr[IW+1:2];
    assign w_r_tag      = r_addr[31:IW+2];
    assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_cnt_zero   = (r_cnt == 4'd0);

    assign w_fill          = (r_state == READ_WAIT)  && w_cnt_zero && !r_is_store;
    assign w_store_done    = (r_state == WRITE_WAIT) && w_cnt_zero;
    assign w_load_hit_idle = (r_state == IDLE) && cache_en && !mem_write && w_lookup_hit;

    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        hit            = 1'b0;
        cache_data_out = '0;
        mem_block      = 2'b00;
        mem_write_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cache_en) begin
                    if (!mem_write) begin
                        if (w_lookup_hit) begin
                            hit            = 1'b1;
                            cache_data_out = r_data[w_idx];
                            mem_block      = addr[1:0];
                        end else begin
                            w_next = READ_WAIT;
                        end
                    end else if (is_LB_SB && !w_lookup_hit) begin
                        // Byte store miss needs the other three lanes first.
                        w_next = READ_WAIT;
                    end else begin
                        w_next = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (w_cnt_zero) begin
                    if (r_is_store) begin
                        w_next = WRITE_WAIT;
                    end else begin
                        w_next = IDLE;
                        if (cache_en) begin
                            hit            = 1'b1;
                            cache_data_out = mem_data_out;
                            mem_block      = r_addr[1:0];
                        end
                    end
                end
            end
            WRITE_WAIT: begin
                mem_write_en = 1'b1;
                if (w_cnt_zero) begin
                    w_next = IDLE;
                    if (cache_en) begin
                        hit       = 1'b1;
                        mem_block = r_addr[1:0];
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_valid       <= '0;
            r_addr        <= '0;
            r_wbyte       <= '0;
            r_is_store    <= 1'b0;
            r_store_hit   <= 1'b0;
            r_cnt         <= '0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_next != IDLE) begin
                        r_addr      <= addr;
                        r_wbyte     <= wdata[7:0];
                        r_is_store  <= mem_write;
                        r_store_hit <= w_lookup_hit;
                        r_cnt       <= LAT_M1;
                        r_mem_addr  <= {addr[31:2], 2'b00};
                        if (mem_write) begin
                            r_mem_data_in <= is_LB_SB
                                ? merge_byte(r_data[w_idx], addr[1:0], wdata[7:0])
                                : wdata;
                        end
                    end
                end
                READ_WAIT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (r_is_store) begin
                        r_mem_data_in <= merge_byte(mem_data_out, r_addr[1:0], r_wbyte);
                        r_cnt         <= LAT_M1;
                    end else begin
                        r_valid[w_r_idx] <= 1'b1;
                    end
                end
                WRITE_WAIT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Line storage has no reset; the valid bits alone define residency.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            if (w_fill) begin
                r_data[w_r_idx] <= mem_data_out;
                r_tag[w_r_idx]  <= w_r_tag;
            end else if (w_store_done && r_store_hit) begin
                // Merged word for byte stores, full wdata for word stores.
                r_data[w_r_idx] <= r_mem_data_in;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_load_hit_idle && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (w_fill && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic            clk;
    logic            rst_b;
    logic            cache_en;
    logic            mem_write;
    logic            is_LB_SB;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic            hit;
    logic [0:3][7:0] cache_data_out;
    logic [1:0]      mem_block;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic            mem_write_en;
    logic [0:3][7:0] mem_data_out;
`ifdef DCACHE_STATS_EN
    logic [31:0]     hit_count;
    logic [31:0]     miss_count;
`endif

    data_cache #(.LINES(8), .MEM_LATENCY(4)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .cache_en       (cache_en),
        .mem_write      (mem_write),
        .is_LB_SB       (is_LB_SB),
        .addr           (addr),
        .wdata          (wdata),
        .hit            (hit),
        .cache_data_out (cache_data_out),
        .mem_block      (mem_block),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_write_en   (mem_write_en),
        .mem_data_out   (mem_data_out)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main-memory model: combinational read, write while strobe is high.
    logic [31:0] mem [64];
    assign mem_data_out = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[7:2]] <= mem_data_in;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    int          t_lat;
    int          t_wcyc;
    logic [31:0] t_data;
    logic [31:0] t_waddr;
    logic [31:0] t_wdat;
    logic [1:0]  t_blk;

    // One core request held until hit; t_lat counts hit=0 cycles before hit.
    task automatic access(input logic we, input logic bt, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cache_en  = 1'b1;
        mem_write = we;
        is_LB_SB  = bt;
        addr      = a;
        wdata     = d;
        t_lat = 0; t_wcyc = 0; t_data = '0; t_waddr = '0; t_wdat = '0; t_blk = '0;
        forever begin
            @(negedge clk);
            if (mem_write_en) begin
                t_wcyc++;
                t_waddr = mem_addr;
                t_wdat  = mem_data_in;
            end
            if (hit) begin
                t_data = cache_data_out;
                t_blk  = mem_block;
                break;
            end
            t_lat++;
            if (t_lat > 60) begin
                check("timeout_waiting_hit", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        cache_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[16] = 32'h1122_3344;   // 0x40
        mem[17] = 32'h0BAD_F00D;   // 0x44
        mem[24] = 32'h5566_7788;   // 0x60
        mem[32] = 32'h99AA_BBCC;   // 0x80

        rst_b = 1'b0; cache_en = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0;
        addr = 32'h40; wdata = 32'h0;
        #2 rst_b = 1'b1;
        #10;
        check("rst_hit",          {31'd0, hit},          32'd0);
        check("rst_mem_write_en", {31'd0, mem_write_en}, 32'd0);
        check("rst_data_out",     cache_data_out,        32'd0);
        check("rst_mem_addr",     mem_addr,              32'd0);
        check("rst_mem_data_in",  mem_data_in,           32'd0);
        check("rst_mem_block",    {30'd0, mem_block},    32'd0);
        @(negedge clk);
        rst_b = 1'b0; cache_en = 1'b0;
        @(negedge clk);
        check("idle_hit_en0", {31'd0, hit}, 32'd0);

        access(1'b0, 1'b0, 32'h40, 32'h0);
        check("lw40_miss_lat",  t_lat,  32'd4);
        check("lw40_miss_data", t_data, 32'h1122_3344);

        access(1'b0, 1'b0, 32'h40, 32'h0);
        check("lw40_hit_lat",  t_lat,  32'd0);
        check("lw40_hit_data", t_data, 32'h1122_3344);

        access(1'b1, 1'b0, 32'h40, 32'hAABB_CCDD);
        check("sw40_wcyc",  t_wcyc,  32'd4);
        check("sw40_waddr", t_waddr, 32'h40);
        check("sw40_wdat",  t_wdat,  32'hAABB_CCDD);
        check("sw40_lat",   t_lat,   32'd4);
        @(negedge clk);
        check("sw40_we_after", {31'd0, mem_write_en}, 32'd0);

        access(1'b0, 1'b0, 32'h40, 32'h0);
        check("lw40_after_sw_lat",  t_lat,  32'd0);
        check("lw40_after_sw_data", t_data, 32'hAABB_CCDD);

        access(1'b1, 1'b1, 32'h43, 32'h0000_00EE);
        check("sb43_wdat",  t_wdat, 32'hAABB_CCEE);
        check("sb43_wcyc",  t_wcyc, 32'd4);
        check("sb43_lat",   t_lat,  32'd4);
        check("sb43_block", {30'd0, t_blk}, 32'd3);

        access(1'b0, 1'b0, 32'h40, 32'h0);
        check("lw40_after_sb_lat",  t_lat,  32'd0);
        check("lw40_after_sb_data", t_data, 32'hAABB_CCEE);

        access(1'b0, 1'b0, 32'h60, 32'h0);
        check("lw60_conflict_lat",  t_lat,  32'd4);
        check("lw60_conflict_data", t_data, 32'h5566_7788);

        access(1'b0, 1'b0, 32'h40, 32'h0);
        check("lw40_evicted_lat",  t_lat,  32'd4);
        check("lw40_evicted_data", t_data, 32'hAABB_CCEE);

        // Byte store miss: RMW read (4) + write (4), line untouched.
        access(1'b1, 1'b1, 32'h81, 32'h0000_005A);
        check("sb81_rmw_lat",   t_lat,   32'd8);
        check("sb81_rmw_wcyc",  t_wcyc,  32'd4);
        check("sb81_rmw_waddr", t_waddr, 32'h80);
        check("sb81_rmw_wdat",  t_wdat,  32'h995A_BBCC);

        access(1'b0, 1'b0, 32'h40, 32'h0);
        check("lw40_after_sbmiss_lat",  t_lat,  32'd0);
        check("lw40_after_sbmiss_data", t_data, 32'hAABB_CCEE);

        access(1'b0, 1'b0, 32'h40, 32'h0);
        check("lw40_hit5_lat", t_lat, 32'd0);

`ifdef DCACHE_STATS_EN
        @(negedge clk);
        check("stats_miss_count", miss_count, 32'd3);
        check("stats_hit_count",  hit_count,  32'd5);
`endif

        // Core drops cache_en mid-miss: no hit, but the fill completes.
        begin
            logic saw_hit;
            saw_hit = 1'b0;
            @(posedge clk); #1;
            cache_en = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0; addr = 32'h44;
            @(posedge clk); #1;
            cache_en = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (hit) saw_hit = 1'b1;
            end
            check("drop_en_no_hit", {31'd0, saw_hit}, 32'd0);
        end
        access(1'b0, 1'b0, 32'h44, 32'h0);
        check("lw44_after_drop_lat",  t_lat,  32'd0);
        check("lw44_after_drop_data", t_data, 32'h0BAD_F00D);

        // Reset in cycle 2 of READ_WAIT.
        @(posedge clk); #1;
        cache_en = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0; addr = 32'h60;
        @(posedge clk);
        @(posedge clk);
        #2 rst_b = 1'b1;
        #1;
        check("midrst_hit",      {31'd0, hit},          32'd0);
        check("midrst_we",       {31'd0, mem_write_en}, 32'd0);
        check("midrst_mem_addr", mem_addr,              32'd0);
        cache_en = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;

        access(1'b0, 1'b0, 32'h60, 32'h0);
        check("lw60_after_rst_lat",  t_lat,  32'd4);
        check("lw60_after_rst_data", t_data, 32'h5566_7788);

        access(1'b0, 1'b0, 32'h44, 32'h0);
        check("lw44_after_rst_lat", t_lat, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have parameter LINES, default 8 (power of two, 2..64), meaning number of direct-mapped one-word lines.
REQ-002 The block SHALL have parameter MEM_LATENCY, default 4 (1..15), meaning cycles main memory needs per read or write.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_b  input  1  asynchronous, active-high reset; name fixed, polarity as stated.
REQ-005 The block SHALL have port cache_en  input  1  core MEM-stage request valid.
REQ-006 The block SHALL have port mem_write  input  1  request is store (1) or load (0).
REQ-007 The block SHALL have port is_LB_SB  input  1  byte access (1) or word access (0).
REQ-008 The block SHALL have port addr  input  32  byte address from ALU result.
REQ-009 The block SHALL have port wdata  input  32  store data (rt value); byte stores use bits [7:0].
REQ-010 The block SHALL have port hit  output  1  request completes this cycle; core stalls while cache_en=1 and hit=0.
REQ-011 The block SHALL have port cache_data_out  output  8x4  addressed word, byte 0 = lowest address.
REQ-012 The block SHALL have port mem_block  output  2  addr[1:0] of completing request.
REQ-013 The block SHALL have ports mem_addr  output  32, mem_data_in  output  8x4, mem_write_en  output  1, and mem_data_out  input  8x4, forming the word-aligned main-memory interface.

Function
REQ-014 The block SHALL index lines by addr[log2(LINES)+1:2], tag with the remaining upper bits, and keep one valid bit per line.
REQ-015 The FSM SHALL have states IDLE, READ_WAIT, WRITE_WAIT.
REQ-016 In IDLE, a load with valid tag match SHALL assert hit combinationally in the same cycle with line data on cache_data_out (zero-cycle latency).
REQ-017 In IDLE, a load miss SHALL enter READ_WAIT, drive mem_addr={addr[31:2],2'b00}, and load a down-counter with MEM_LATENCY-1.
REQ-018 In READ_WAIT, after MEM_LATENCY cycles, the block SHALL write mem_data_out into the line, set valid, update the tag, assert hit for exactly one cycle with that data, and return to IDLE.
REQ-019 A store SHALL be write-through, no-allocate: in IDLE it enters WRITE_WAIT and holds mem_write_en=1 with mem_addr and mem_data_in stable for MEM_LATENCY cycles, then asserts hit for one cycle and returns to IDLE.
REQ-020 A word store on a tag match SHALL update the whole line; a byte store on a tag match SHALL update only byte addr[1:0] of the line; a store on a miss SHALL leave the line unchanged.
REQ-021 A byte store SHALL place wdata[7:0] in byte lane addr[1:0] of mem_data_in and drive the other lanes from the line if valid and tag-matching, otherwise from a preceding MEM_LATENCY read (read-modify-write via READ_WAIT then WRITE_WAIT).
REQ-022 Word accesses SHALL ignore addr[1:0].
REQ-023 mem_write_en SHALL be 0 in every state other than WRITE_WAIT.
REQ-024 hit SHALL be 0 whenever cache_en=0.
REQ-025 Inputs SHALL be held stable by the stalled core; if cache_en drops mid-miss, the block SHALL finish the transaction without asserting hit.
REQ-026 Counter wrap SHALL NOT occur: the counter saturates at 0, and the transition happens on the cycle it reads 0.

Reset
REQ-027 rst_b=1 SHALL immediately clear all valid bits, set the FSM to IDLE and the counter to 0, and force hit=0 and mem_write_en=0; cache_data_out, mem_block, mem_addr, and mem_data_in SHALL be 0.
REQ-028 Reset during READ_WAIT or WRITE_WAIT SHALL abandon the transaction, leaving no line update.

Configuration
REQ-029 With DCACHE_STATS_EN defined, the block SHALL add 32-bit outputs hit_count and miss_count, reset to 0, incremented once per completed load hit and load miss respectively, and saturating at 0xFFFFFFFF.
REQ-030 Without DCACHE_STATS_EN defined, those ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-031 The bench SHALL check: reset, then LW 0x40 with memory word 0x11223344 -> hit=0 for 4 cycles, then hit=1 with data 0x11223344; LW 0x40 again -> hit=1 in the same cycle.
REQ-032 The bench SHALL check: SW 0x40 data 0xAABBCCDD after the fill -> mem_write_en=1 for exactly 4 cycles at mem_addr 0x40; the following LW 0x40 hits with 0xAABBCCDD.
REQ-033 The bench SHALL check: SB 0x43 data 0xEE on a resident line -> mem_data_in = {0xAA,0xBB,0xCC,0xEE} byte order 0..3 reversed per lane 3=0xEE, and the line is updated.
REQ-034 The bench SHALL check: LW 0x60 with LINES=8 (same index as 0x40, different tag... index 0 vs 0) -> miss, refill, and a later LW 0x40 misses again.
REQ-035 The bench SHALL check: rst_b pulse at cycle 2 of READ_WAIT -> FSM in IDLE, hit=0, and a subsequent LW to the same address misses.
REQ-036 The bench SHALL check, with DCACHE_STATS_EN defined: 3 load misses and 5 load hits -> miss_count=3 and hit_count=5; stores change neither counter.
